// File: rtl/barcode_serializer.sv
// Frames captured ticket fields with guard patterns and an even-parity bit,
// then shifts the 62-bit frame out as a bar/space stream, MODULE_WIDTH clocks per bit.
module barcode_serializer #(
    parameter int unsigned MODULE_WIDTH = 4
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        Start,
    input  logic        Abort,
    input  logic [44:0] StudentNumbers,
    input  logic [4:0]  ValueToPay,
    input  logic        P,
    input  logic [3:0]  D,
    output logic        BarOut,
    output logic        Busy,
    output logic        Done,
    output logic [5:0]  BitIndex
);

    localparam logic [7:0] MOD_LAST = 8'(MODULE_WIDTH - 1);
    localparam logic [5:0] BIT_LAST = 6'd61;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic payload_parity(input logic [54:0] payload);
        return ^payload;
    endfunction

    // frame[i] is the i-th bit on the wire, so BitIndex indexes it directly
    function automatic logic [61:0] build_frame(input logic [44:0] sn, input logic [4:0] vtp,
                                                input logic p, input logic [3:0] d);
        logic [54:0] payload;
        logic [61:0] seq;
        logic [61:0] frame;
        payload = {sn, vtp, p, d};
        seq     = {3'b101, payload, payload_parity(payload), 3'b101};
        for (int i = 0; i < 62; i++) begin
            frame[i] = seq[61 - i];
        end
        return frame;
    endfunction

    state_t      state_r;
    logic [61:0] frame_r;
    logic [7:0]  mod_cnt_r;
    logic [5:0]  bit_idx_r;
    logic        bar_r;
    logic        busy_r;
    logic        done_r;

    logic [61:0] frame_load_s;
    logic [5:0]  bit_next_s;
    logic        bar_next_s;

    assign frame_load_s = build_frame(StudentNumbers, ValueToPay, P, D);

    // Next bit to present after a module wrap; only consumed below the last bit
    always_comb begin
        bit_next_s = bit_idx_r + 6'd1;
        if (bit_idx_r != BIT_LAST) begin
            bar_next_s = frame_r[bit_next_s];
        end else begin
            bar_next_s = 1'b0;
        end
    end

    // Sequencer: capture, bit/module timing, completion pulse and abort
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_r   <= ST_IDLE;
            frame_r   <= 62'd0;
            mod_cnt_r <= 8'd0;
            bit_idx_r <= 6'd0;
            bar_r     <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    mod_cnt_r <= 8'd0;
                    bit_idx_r <= 6'd0;
                    done_r    <= 1'b0;
                    if (Start && !Abort) begin
                        frame_r <= frame_load_s;
                        bar_r   <= frame_load_s[0];
                        busy_r  <= 1'b1;
                        state_r <= ST_SEND;
                    end else begin
                        bar_r   <= 1'b0;
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (Abort) begin
                        mod_cnt_r <= 8'd0;
                        bit_idx_r <= 6'd0;
                        bar_r     <= 1'b0;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else if (mod_cnt_r == MOD_LAST) begin
                        mod_cnt_r <= 8'd0;
                        if (bit_idx_r == BIT_LAST) begin
                            bit_idx_r <= 6'd0;
                            bar_r     <= 1'b0;
                            busy_r    <= 1'b0;
                            done_r    <= 1'b1;
                            state_r   <= ST_DONE;
                        end else begin
                            bit_idx_r <= bit_next_s;
                            bar_r     <= bar_next_s;
                        end
                    end else begin
                        mod_cnt_r <= mod_cnt_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    mod_cnt_r <= 8'd0;
                    bit_idx_r <= 6'd0;
                    bar_r     <= 1'b0;
                    busy_r    <= 1'b0;
                    done_r    <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign BarOut   = bar_r;
    assign Busy     = busy_r;
    assign Done     = done_r;
    assign BitIndex = bit_idx_r;

endmodule

// File: tb/tb_barcode_serializer.sv
// Directed bench: one DUT at MODULE_WIDTH=4, one at MODULE_WIDTH=1, sharing clock and payload.
module tb_barcode_serializer;

    logic        Clk = 1'b0;
    logic        Rst_n = 1'b1;
    logic        start4 = 1'b0;
    logic        start1 = 1'b0;
    logic        Abort = 1'b0;
    logic [44:0] sn = 45'd0;
    logic [4:0]  vtp = 5'd0;
    logic        P = 1'b0;
    logic [3:0]  D = 4'd0;

    logic        bar4, busy4, done4;
    logic [5:0]  idx4;
    logic        bar1, busy1, done1;
    logic [5:0]  idx1;

    int tests = 0;
    int fails = 0;

    barcode_serializer #(.MODULE_WIDTH(4)) dut4 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(start4), .Abort(Abort),
        .StudentNumbers(sn), .ValueToPay(vtp), .P(P), .D(D),
        .BarOut(bar4), .Busy(busy4), .Done(done4), .BitIndex(idx4)
    );

    barcode_serializer #(.MODULE_WIDTH(1)) dut1 (
        .Clk(Clk), .Rst_n(Rst_n), .Start(start1), .Abort(Abort),
        .StudentNumbers(sn), .ValueToPay(vtp), .P(P), .D(D),
        .BarOut(bar1), .Busy(busy1), .Done(done1), .BitIndex(idx1)
    );

    always #5 Clk = ~Clk;

    // Wire order: bit n of the frame is seq[61-n]; parity supplied by hand
    function automatic logic [61:0] seq_of(input logic [44:0] s, input logic [4:0] v,
                                           input logic p, input logic [3:0] d, input logic par);
        return {3'b101, s, v, p, d, par, 3'b101};
    endfunction

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset;
        #2 Rst_n = 1'b0;
        #2;
        tests++;
        if ({bar4, busy4, done4, idx4, bar1, busy1, done1, idx1} !== 18'd0) begin
            fails++;
            $display("FAIL reset_async got %b required 0", {bar4, busy4, done4, idx4, bar1, busy1, done1, idx1});
        end
        tick; tick;
        Rst_n = 1'b1;
        tick; tick;
        tests++;
        if ({bar4, busy4, done4, idx4} !== 9'd0) begin
            fails++;
            $display("FAIL reset_idle got %b required 0", {bar4, busy4, done4, idx4});
        end
    endtask

    task automatic test_zero_frame;
        logic [61:0] exp;
        sn = 45'd0; vtp = 5'd0; P = 1'b0; D = 4'd0;
        exp = seq_of(45'd0, 5'd0, 1'b0, 4'd0, 1'b0);
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        for (int c = 0; c < 248; c++) begin
            tests++;
            if (busy4 !== 1'b1 || done4 !== 1'b0 || idx4 !== 6'(c / 4) || bar4 !== exp[61 - c / 4]) begin
                fails++;
                $display("FAIL zero_frame c=%0d got busy=%b done=%b idx=%0d bar=%b required 1 0 %0d %b",
                         c, busy4, done4, idx4, bar4, c / 4, exp[61 - c / 4]);
            end
            tick;
        end
        tests++;
        if (done4 !== 1'b1 || busy4 !== 1'b0 || bar4 !== 1'b0 || idx4 !== 6'd0) begin
            fails++;
            $display("FAIL zero_done got done=%b busy=%b bar=%b idx=%0d required 1 0 0 0", done4, busy4, bar4, idx4);
        end
        tick;
        tests++;
        if (done4 !== 1'b0) begin
            fails++;
            $display("FAIL zero_done_pulse got %b required 0", done4);
        end
    endtask

    task automatic test_parity;
        logic [61:0] exp;
        logic [4:0]  exp_vtp;
        exp_vtp = 5'b01010;
        sn = 45'd0; vtp = 5'd10; P = 1'b1; D = 4'b0011;
        exp = seq_of(45'd0, 5'd10, 1'b1, 4'b0011, 1'b1);
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        for (int c = 0; c < 248; c++) begin
            tests++;
            if (busy4 !== 1'b1 || idx4 !== 6'(c / 4) || bar4 !== exp[61 - c / 4]) begin
                fails++;
                $display("FAIL parity_frame c=%0d got idx=%0d bar=%b required %0d %b", c, idx4, bar4, c / 4, exp[61 - c / 4]);
            end
            if (c == 58 * 4) begin
                tests++;
                if (bar4 !== 1'b1) begin
                    fails++;
                    $display("FAIL parity_bit got %b required 1", bar4);
                end
            end
            if (c % 4 == 1 && c / 4 >= 48 && c / 4 <= 52) begin
                tests++;
                if (bar4 !== exp_vtp[52 - c / 4]) begin
                    fails++;
                    $display("FAIL value_bit n=%0d got %b required %b", c / 4, bar4, exp_vtp[52 - c / 4]);
                end
            end
            tick;
        end
        tests++;
        if (done4 !== 1'b1 || busy4 !== 1'b0) begin
            fails++;
            $display("FAIL parity_done got done=%b busy=%b required 1 0", done4, busy4);
        end
        tick;
    endtask

    task automatic test_restart_ignored;
        logic [61:0] exp;
        int          extra_done;
        sn = 45'd3; vtp = 5'd1; P = 1'b0; D = 4'd0;
        exp = seq_of(45'd3, 5'd1, 1'b0, 4'd0, 1'b1);
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        for (int c = 0; c < 248; c++) begin
            if (c == 80) begin
                start4 = 1'b1;
                sn = {45{1'b1}}; vtp = 5'h1F; P = 1'b1; D = 4'hF;
            end
            if (c == 81) start4 = 1'b0;
            tests++;
            if (busy4 !== 1'b1 || done4 !== 1'b0 || idx4 !== 6'(c / 4) || bar4 !== exp[61 - c / 4]) begin
                fails++;
                $display("FAIL restart_frame c=%0d got busy=%b done=%b idx=%0d bar=%b required 1 0 %0d %b",
                         c, busy4, done4, idx4, bar4, c / 4, exp[61 - c / 4]);
            end
            tick;
        end
        tests++;
        if (done4 !== 1'b1) begin
            fails++;
            $display("FAIL restart_done got %b required 1", done4);
        end
        extra_done = 0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (done4 === 1'b1 || busy4 === 1'b1) extra_done++;
        end
        tests++;
        if (extra_done !== 0) begin
            fails++;
            $display("FAIL restart_single got %0d extra busy/done cycles required 0", extra_done);
        end
    endtask

    task automatic test_abort;
        logic [61:0] exp;
        sn = 45'd0; vtp = 5'd10; P = 1'b1; D = 4'b0011;
        exp = seq_of(45'd0, 5'd10, 1'b1, 4'b0011, 1'b1);
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        for (int c = 0; c < 120; c++) tick;
        tests++;
        if (idx4 !== 6'd30 || bar4 !== exp[61 - 30]) begin
            fails++;
            $display("FAIL abort_pre got idx=%0d bar=%b required 30 %b", idx4, bar4, exp[61 - 30]);
        end
        Abort = 1'b1;
        tick;
        Abort = 1'b0;
        tests++;
        if (busy4 !== 1'b0 || bar4 !== 1'b0 || idx4 !== 6'd0 || done4 !== 1'b0) begin
            fails++;
            $display("FAIL abort_stop got busy=%b bar=%b idx=%0d done=%b required 0 0 0 0", busy4, bar4, idx4, done4);
        end
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        tests++;
        if (busy4 !== 1'b1 || idx4 !== 6'd0 || bar4 !== 1'b1 || done4 !== 1'b0) begin
            fails++;
            $display("FAIL abort_restart got busy=%b idx=%0d bar=%b done=%b required 1 0 1 0", busy4, idx4, bar4, done4);
        end
        // Abort on the final module cycle must beat the transition to DONE
        for (int c = 0; c < 247; c++) tick;
        tests++;
        if (idx4 !== 6'd61 || busy4 !== 1'b1) begin
            fails++;
            $display("FAIL abort_last_pre got idx=%0d busy=%b required 61 1", idx4, busy4);
        end
        Abort = 1'b1;
        tick;
        Abort = 1'b0;
        tests++;
        if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            fails++;
            $display("FAIL abort_last got done=%b busy=%b required 0 0", done4, busy4);
        end
        Abort = 1'b1;
        start4 = 1'b1;
        tick;
        Abort = 1'b0;
        start4 = 1'b0;
        tests++;
        if (busy4 !== 1'b0 || bar4 !== 1'b0) begin
            fails++;
            $display("FAIL abort_with_start got busy=%b bar=%b required 0 0", busy4, bar4);
        end
        tick;
    endtask

    task automatic test_async_reset;
        int busy_seen;
        sn = 45'd0; vtp = 5'd10; P = 1'b1; D = 4'b0011;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        for (int c = 0; c < 162; c++) tick;
        tests++;
        if (idx4 !== 6'd40 || busy4 !== 1'b1) begin
            fails++;
            $display("FAIL rst_pre got idx=%0d busy=%b required 40 1", idx4, busy4);
        end
        #2 Rst_n = 1'b0;
        #1;
        tests++;
        if ({bar4, busy4, done4, idx4} !== 9'd0) begin
            fails++;
            $display("FAIL rst_mid got %b required 0", {bar4, busy4, done4, idx4});
        end
        #2 Rst_n = 1'b1;
        busy_seen = 0;
        for (int c = 0; c < 5; c++) begin
            tick;
            if (busy4 !== 1'b0 || idx4 !== 6'd0 || bar4 !== 1'b0) busy_seen++;
        end
        tests++;
        if (busy_seen !== 0) begin
            fails++;
            $display("FAIL rst_idle got %0d active cycles required 0", busy_seen);
        end
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        tests++;
        if (busy4 !== 1'b1 || bar4 !== 1'b1 || idx4 !== 6'd0) begin
            fails++;
            $display("FAIL rst_restart got busy=%b bar=%b idx=%0d required 1 1 0", busy4, bar4, idx4);
        end
        Abort = 1'b1;
        tick;
        Abort = 1'b0;
        tick;
    endtask

    task automatic test_width1;
        logic [61:0] exp;
        sn = {45{1'b1}}; vtp = 5'd0; P = 1'b0; D = 4'd0;
        exp = seq_of({45{1'b1}}, 5'd0, 1'b0, 4'd0, 1'b1);
        start1 = 1'b1;
        tick;
        start1 = 1'b0;
        for (int c = 0; c < 62; c++) begin
            tests++;
            if (busy1 !== 1'b1 || done1 !== 1'b0 || idx1 !== 6'(c) || bar1 !== exp[61 - c]) begin
                fails++;
                $display("FAIL w1_frame c=%0d got busy=%b done=%b idx=%0d bar=%b required 1 0 %0d %b",
                         c, busy1, done1, idx1, bar1, c, exp[61 - c]);
            end
            if (c == 58) begin
                tests++;
                if (bar1 !== 1'b1) begin
                    fails++;
                    $display("FAIL w1_parity got %b required 1", bar1);
                end
            end
            tick;
        end
        tests++;
        if (done1 !== 1'b1 || busy1 !== 1'b0 || bar1 !== 1'b0) begin
            fails++;
            $display("FAIL w1_done got done=%b busy=%b bar=%b required 1 0 0", done1, busy1, bar1);
        end
        tick;
        tests++;
        if (done1 !== 1'b0) begin
            fails++;
            $display("FAIL w1_done_pulse got %b required 0", done1);
        end
    endtask

    initial begin
        test_reset;
        test_zero_frame;
        test_parity;
        test_restart_ignored;
        test_abort;
        test_async_reset;
        test_width1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
